imem_responder: RTL and testbench
=================================

# imem_responder

Instruction-memory responder that serves the fetch addresses the program counter issues and returns instruction words to the IF/ID boundary. It holds a word-organised instruction store and answers each read request after a fixed, parameterised number of wait states. It drives a stall back to the PC while a request is in flight and flags misaligned or out-of-range fetches. A loader write port fills the store before and during execution.

## Interface
- `BASE_ADDR`, default 32'h00000000: byte address of store word 0; matches the PC reset address.
- `DEPTH_WORDS`, default 1024: number of 32-bit words; power of two, 2 to 65536.
- `WAIT_CYCLES`, default 0: extra cycles before a response; 0 to 15.
- `NOP_INSN`, default 32'h00000013: word driven on `o_rdata` whenever no valid instruction is presented.

Ports:
- `i_clk` in 1: global clock; all state updates on the rising edge.
- `i_rst` in 1: synchronous, active-high reset.
- `i_req` in 1: read request; `i_raddr` is sampled when this is high and the block is accepting.
- `i_raddr` in 32: byte fetch address.
- `i_flush` in 1: cancels any in-flight request; asserted on a taken branch.
- `i_wen` in 1: loader write enable.
- `i_waddr` in 32: loader byte address.
- `i_wdata` in 32: loader write data.
- `o_rdata` out 32: fetched instruction.
- `o_valid` out 1: `o_rdata` and `o_fault` are valid this cycle.
- `o_fault` out 1: the response belongs to a misaligned or out-of-range fetch.
- `o_busy` out 1: request in flight and not accepting; feeds the PC hold input.

## Operation
- Index arithmetic:
  - `idx = (raddr - BASE_ADDR) >> 2`, computed 32-bit unsigned.
  - An address is in range iff `raddr >= BASE_ADDR` and `idx < DEPTH_WORDS`.
  - An address is misaligned iff `raddr[1:0] != 0`.
- FSM states: IDLE, WAIT, RESP.
  - **IDLE**, accepting.
    - `i_req & ~i_flush`: latch the address and fault status, read the store, then go to WAIT if `WAIT_CYCLES > 0`, else RESP.
    - Otherwise stay in IDLE.
  - **WAIT**, not accepting.
    - A down-counter is loaded with `WAIT_CYCLES - 1` on entry.
    - When the counter reaches 0, go to RESP.
    - `i_req` is ignored in this state.
  - **RESP**, accepting.
    - `o_valid = 1` for exactly one cycle.
    - A new `i_req & ~i_flush` in the same cycle is accepted exactly as from IDLE, giving back-to-back throughput when `WAIT_CYCLES = 0`.
    - With no new request, return to IDLE.
- Fault handling: a misaligned or out-of-range fetch completes with the normal latency, with `o_fault = 1`, `o_rdata = NOP_INSN`, and no store read.
- Flush:
  - `i_flush` in any state cancels the pending response: next state is IDLE, the counter is cleared, and `o_valid`/`o_fault` stay 0 for that request.
  - Flush has priority over a same-cycle `i_req`; that request is dropped.
  - If flush lands in the RESP cycle itself, that cycle's response is still delivered, because `o_valid` is already registered.
- Writes:
  - Performed when `i_wen`, the address is aligned, and the address is in range; any other write is silently dropped.
  - Writes are accepted in every state.
  - A read and a write to the same word in the same cycle return the old data (read-before-write).
- Store contents are not affected by reset.

## Timing
- Reset values, one cycle after `i_rst`: state IDLE, counter 0, `o_valid = 0`, `o_fault = 0`, `o_busy = 0`, `o_rdata = NOP_INSN`.
  - Reset mid-request abandons that request.
  - Reset has priority over `i_req` and `i_flush`.
- Latency: request accepted on edge N gives `o_valid` high during cycle N+1+`WAIT_CYCLES`.
- `o_busy` is registered and is high exactly while in WAIT: cycles N+1 through N+`WAIT_CYCLES`. It is never high when `WAIT_CYCLES = 0`.
- `o_rdata` holds the last response until the next response, reset, or flush. Flush loads `NOP_INSN` on the next edge.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- **Reset then fetch, `WAIT_CYCLES = 0`:** preload word 0 = 32'h00500093; request 0x0 on cycle 1 -> `o_valid = 1`, `o_rdata = 32'h00500093` on cycle 2, `o_busy` never 1.
- **Back-to-back, `WAIT_CYCLES = 0`:** requests 0x0, 0x4, 0x8 on consecutive cycles -> three consecutive valid responses carrying words 0, 1, 2.
- **Wait states, `WAIT_CYCLES = 3`:** request 0x4 on cycle 1 -> `o_busy` high on cycles 2–4, `o_valid` on cycle 5; a request on cycle 3 is ignored.
- **Faults:** request 0x2 -> `o_fault = 1`, `o_rdata = 32'h00000013`; request `BASE_ADDR + 4*DEPTH_WORDS` -> `o_fault = 1`; request `BASE_ADDR - 4` with `BASE_ADDR = 32'h100` -> `o_fault = 1`.
- **Flush, `WAIT_CYCLES = 2`:** request, then `i_flush` on cycle 2 -> no `o_valid` for that request, `o_busy` low on cycle 3, `o_rdata = NOP_INSN`; a new request on cycle 3 is answered normally.
- **Loader:** write 32'hDEADBEEF to 0x8 while a same-cycle read of 0x8 is issued -> old word returned; the next read of 0x8 -> 32'hDEADBEEF. A misaligned write to 0xA leaves memory unchanged.

Source files
------------

// File: rtl/imem_responder_if.sv
// Fetch/loader bus between the PC stage, the program loader and the instruction memory responder.
interface imem_responder_if;
    logic        i_req;
    logic [31:0] i_raddr;
    logic        i_flush;
    logic        i_wen;
    logic [31:0] i_waddr;
    logic [31:0] i_wdata;
    logic [31:0] o_rdata;
    logic        o_valid;
    logic        o_fault;
    logic        o_busy;

    modport master (
        output i_req, i_raddr, i_flush, i_wen, i_waddr, i_wdata,
        input  o_rdata, o_valid, o_fault, o_busy
    );

    modport slave (
        input  i_req, i_raddr, i_flush, i_wen, i_waddr, i_wdata,
        output o_rdata, o_valid, o_fault, o_busy
    );
endinterface

// File: rtl/imem_responder.sv
// Word-organised instruction store answering fetches after WAIT_CYCLES wait states,
// with PC stall, fault flagging for bad fetches, flush cancel and a loader write port.
module imem_responder #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_CYCLES = 0,
    parameter logic [31:0] NOP_INSN    = 32'h0000_0013
) (
    input  logic             i_clk,
    input  logic             i_rst,
    imem_responder_if.slave  bus
);
    localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    logic [31:0]      mem [0:DEPTH_WORDS-1];
    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             valid_q;
    logic             fault_q;
    logic             busy_q;
    logic [31:0]      rdata_q;
    logic             pend_fault;
    logic [31:0]      pend_data;

    logic [31:0]      rd_word;
    logic [31:0]      wr_word;
    logic             rd_fault;
    logic             wr_ok;
    logic [IDX_W-1:0] rd_idx;
    logic [IDX_W-1:0] wr_idx;

    // Word index and legality of both the fetch and the loader address.
    always_comb begin
        rd_word  = (bus.i_raddr - BASE_ADDR) >> 2;
        wr_word  = (bus.i_waddr - BASE_ADDR) >> 2;
        rd_fault = (bus.i_raddr[1:0] != 2'b00) || (bus.i_raddr < BASE_ADDR)
                   || (rd_word >= DEPTH_WORDS);
        wr_ok    = (bus.i_waddr[1:0] == 2'b00) && (bus.i_waddr >= BASE_ADDR)
                   && (wr_word < DEPTH_WORDS);
        rd_idx   = rd_word[IDX_W-1:0];
        wr_idx   = wr_word[IDX_W-1:0];
    end

    // Store is not reset; a same-cycle read sees the old word through NBA ordering.
    always_ff @(posedge i_clk) begin
        if (bus.i_wen && wr_ok) begin
            mem[wr_idx] <= bus.i_wdata;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state      <= S_IDLE;
            cnt        <= '0;
            valid_q    <= 1'b0;
            fault_q    <= 1'b0;
            busy_q     <= 1'b0;
            rdata_q    <= NOP_INSN;
            pend_fault <= 1'b0;
            pend_data  <= NOP_INSN;
        end else begin
            valid_q <= 1'b0;
            fault_q <= 1'b0;
            busy_q  <= 1'b0;
            case (state)
                S_IDLE, S_RESP: begin
                    if (bus.i_flush) begin
                        state   <= S_IDLE;
                        cnt     <= '0;
                        rdata_q <= NOP_INSN;
                    end else if (bus.i_req) begin
                        if (WAIT_CYCLES == 0) begin
                            state   <= S_RESP;
                            valid_q <= 1'b1;
                            fault_q <= rd_fault;
                            rdata_q <= rd_fault ? NOP_INSN : mem[rd_idx];
                        end else begin
                            state      <= S_WAIT;
                            cnt        <= CNT_W'(WAIT_CYCLES - 1);
                            busy_q     <= 1'b1;
                            pend_fault <= rd_fault;
                            pend_data  <= rd_fault ? NOP_INSN : mem[rd_idx];
                        end
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_WAIT: begin
                    if (bus.i_flush) begin
                        state   <= S_IDLE;
                        cnt     <= '0;
                        rdata_q <= NOP_INSN;
                    end else if (cnt == '0) begin
                        state   <= S_RESP;
                        valid_q <= 1'b1;
                        fault_q <= pend_fault;
                        rdata_q <= pend_data;
                    end else begin
                        cnt    <= cnt - CNT_W'(1);
                        busy_q <= 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    assign bus.o_rdata = rdata_q;
    assign bus.o_valid = valid_q;
    assign bus.o_fault = fault_q;
    assign bus.o_busy  = busy_q;
endmodule

// File: tb/tb_imem_responder.sv
// Bench for imem_responder: three configurations share one stimulus stream and are
// checked against a due-time reference model, plus a vector table and corner sequences.
module tb_imem_responder;
    localparam int unsigned NI    = 3;
    localparam int unsigned DEPTH = 16;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    typedef struct {
        logic        req;
        logic [31:0] raddr;
        logic        flush;
        logic        wen;
        logic [31:0] waddr;
        logic [31:0] wdata;
        logic        e_valid;
        logic        e_fault;
        logic [31:0] e_rdata;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic        flush = 1'b0;
    logic        wen = 1'b0;
    logic [31:0] raddr = '0;
    logic [31:0] waddr = '0;
    logic [31:0] wdata = '0;
    int          cyc = 0;
    int          n_err = 0;
    int          n_chk = 0;

    always #5 clk = ~clk;

    imem_responder_if bus0 ();
    imem_responder_if bus1 ();
    imem_responder_if bus2 ();

    assign bus0.i_req = req;   assign bus0.i_raddr = raddr; assign bus0.i_flush = flush;
    assign bus0.i_wen = wen;   assign bus0.i_waddr = waddr; assign bus0.i_wdata = wdata;
    assign bus1.i_req = req;   assign bus1.i_raddr = raddr; assign bus1.i_flush = flush;
    assign bus1.i_wen = wen;   assign bus1.i_waddr = waddr; assign bus1.i_wdata = wdata;
    assign bus2.i_req = req;   assign bus2.i_raddr = raddr; assign bus2.i_flush = flush;
    assign bus2.i_wen = wen;   assign bus2.i_waddr = waddr; assign bus2.i_wdata = wdata;

    imem_responder #(.BASE_ADDR(32'h0), .DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0), .NOP_INSN(NOP))
        u0 (.i_clk(clk), .i_rst(rst), .bus(bus0));
    imem_responder #(.BASE_ADDR(32'h100), .DEPTH_WORDS(DEPTH), .WAIT_CYCLES(3), .NOP_INSN(NOP))
        u1 (.i_clk(clk), .i_rst(rst), .bus(bus1));
    imem_responder #(.BASE_ADDR(32'h0), .DEPTH_WORDS(DEPTH), .WAIT_CYCLES(2), .NOP_INSN(NOP))
        u2 (.i_clk(clk), .i_rst(rst), .bus(bus2));

    logic [31:0] a_rdata [NI];
    logic        a_valid [NI];
    logic        a_fault [NI];
    logic        a_busy  [NI];
    assign a_rdata[0] = bus0.o_rdata; assign a_valid[0] = bus0.o_valid;
    assign a_fault[0] = bus0.o_fault; assign a_busy[0]  = bus0.o_busy;
    assign a_rdata[1] = bus1.o_rdata; assign a_valid[1] = bus1.o_valid;
    assign a_fault[1] = bus1.o_fault; assign a_busy[1]  = bus1.o_busy;
    assign a_rdata[2] = bus2.o_rdata; assign a_valid[2] = bus2.o_valid;
    assign a_fault[2] = bus2.o_fault; assign a_busy[2]  = bus2.o_busy;

    // Reference model: a pending response simply carries the cycle it is due on.
    logic        m_pend  [NI];
    int          m_due   [NI];
    logic [31:0] m_pdata [NI];
    logic        m_pfault[NI];
    logic [31:0] m_rdata [NI];
    logic        m_valid [NI];
    logic        m_fault [NI];
    logic        m_busy  [NI];
    logic [31:0] m_mem   [NI][DEPTH];

    function automatic int wait_of(int k);
        return (k == 1) ? 3 : ((k == 2) ? 2 : 0);
    endfunction

    function automatic logic [31:0] base_of(int k);
        return (k == 1) ? 32'h100 : 32'h0;
    endfunction

    function automatic logic bad_addr(int k, logic [31:0] a);
        longint off;
        off = longint'(a) - longint'(base_of(k));
        return (a % 4 != 0) || (off < 0) || (off >= longint'(4 * DEPTH));
    endfunction

    function automatic int word_of(int k, logic [31:0] a);
        return int'((longint'(a) - longint'(base_of(k))) / 4);
    endfunction

    task automatic model_update();
        for (int k = 0; k < NI; k++) begin
            if (rst) begin
                m_pend[k] = 1'b0; m_valid[k] = 1'b0; m_fault[k] = 1'b0;
                m_busy[k] = 1'b0; m_rdata[k] = NOP;
            end else begin
                logic        f;
                logic [31:0] d;
                m_valid[k] = 1'b0;
                m_fault[k] = 1'b0;
                if (flush) begin
                    m_pend[k]  = 1'b0;
                    m_rdata[k] = NOP;
                end else if (m_pend[k]) begin
                    if (cyc + 1 == m_due[k]) begin
                        m_valid[k] = 1'b1; m_fault[k] = m_pfault[k];
                        m_rdata[k] = m_pdata[k]; m_pend[k] = 1'b0;
                    end
                end else if (req) begin
                    f = bad_addr(k, raddr);
                    d = f ? NOP : m_mem[k][word_of(k, raddr)];
                    if (wait_of(k) == 0) begin
                        m_valid[k] = 1'b1; m_fault[k] = f; m_rdata[k] = d;
                    end else begin
                        m_pend[k] = 1'b1; m_due[k] = cyc + 1 + wait_of(k);
                        m_pdata[k] = d; m_pfault[k] = f;
                    end
                end
                m_busy[k] = m_pend[k];
            end
            if (wen && !bad_addr(k, waddr)) m_mem[k][word_of(k, waddr)] = wdata;
        end
        cyc++;
    endtask

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    task automatic check_model();
        for (int k = 0; k < NI; k++) begin
            chk($sformatf("u%0d.valid", k), 32'(a_valid[k]), 32'(m_valid[k]));
            chk($sformatf("u%0d.fault", k), 32'(a_fault[k]), 32'(m_fault[k]));
            chk($sformatf("u%0d.busy", k),  32'(a_busy[k]),  32'(m_busy[k]));
            chk($sformatf("u%0d.rdata", k), a_rdata[k], m_rdata[k]);
        end
    endtask

    task automatic step(input logic r, input logic [31:0] ra, input logic f,
                        input logic w, input logic [31:0] wa, input logic [31:0] wd);
        req = r; raddr = ra; flush = f; wen = w; waddr = wa; wdata = wd;
        @(posedge clk);
        model_update();
        #1;
        check_model();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 1'b0, '0, '0);
    endtask

    function automatic vec_t mk(logic r, logic [31:0] ra, logic f, logic w, logic [31:0] wa,
                                logic [31:0] wd, logic ev, logic ef, logic [31:0] er);
        vec_t v;
        v.req = r; v.raddr = ra; v.flush = f; v.wen = w; v.waddr = wa; v.wdata = wd;
        v.e_valid = ev; v.e_fault = ef; v.e_rdata = er;
        return v;
    endfunction

    function automatic logic [31:0] rnd_addr();
        int unsigned s;
        s = $urandom_range(0, 9);
        if (s <= 3)      return 32'(4 * $urandom_range(0, 15));
        else if (s <= 6) return 32'h100 + 32'(4 * $urandom_range(0, 15));
        else if (s == 7) return 32'(4 * $urandom_range(0, 15) + $urandom_range(1, 3));
        else if (s == 8) return ($urandom_range(0, 1) == 1) ? 32'h40 : 32'h140;
        else             return 32'($urandom());
    endfunction

    vec_t vt [15];

    initial begin
        // WAIT_CYCLES = 0 instance (u0) expectations, one row per clock edge.
        vt[0]  = mk(0, 32'h0,  0, 1, 32'h0, 32'h0050_0093, 0, 0, NOP);
        vt[1]  = mk(0, 32'h0,  0, 1, 32'h4, 32'h1111_1111, 0, 0, NOP);
        vt[2]  = mk(0, 32'h0,  0, 1, 32'h8, 32'h2222_2222, 0, 0, NOP);
        vt[3]  = mk(1, 32'h0,  0, 0, 32'h0, 32'h0,         1, 0, 32'h0050_0093);
        vt[4]  = mk(1, 32'h4,  0, 0, 32'h0, 32'h0,         1, 0, 32'h1111_1111);
        vt[5]  = mk(1, 32'h8,  0, 0, 32'h0, 32'h0,         1, 0, 32'h2222_2222);
        vt[6]  = mk(0, 32'h0,  0, 0, 32'h0, 32'h0,         0, 0, 32'h2222_2222);
        vt[7]  = mk(1, 32'h2,  0, 0, 32'h0, 32'h0,         1, 1, NOP);
        vt[8]  = mk(1, 32'h40, 0, 0, 32'h0, 32'h0,         1, 1, NOP);
        vt[9]  = mk(1, 32'h8,  0, 1, 32'h8, 32'hDEAD_BEEF, 1, 0, 32'h2222_2222);
        vt[10] = mk(1, 32'h8,  0, 0, 32'h0, 32'h0,         1, 0, 32'hDEAD_BEEF);
        vt[11] = mk(0, 32'h0,  0, 1, 32'hA, 32'h1234_5678, 0, 0, 32'hDEAD_BEEF);
        vt[12] = mk(1, 32'h8,  0, 0, 32'h0, 32'h0,         1, 0, 32'hDEAD_BEEF);
        vt[13] = mk(1, 32'h8,  1, 0, 32'h0, 32'h0,         0, 0, NOP);
        vt[14] = mk(1, 32'hFFFF_FFFC, 0, 0, 32'h0, 32'h0,  1, 1, NOP);

        rst = 1'b1;
        idle(2);
        chk("reset.valid", 32'(bus0.o_valid), 32'h0);
        chk("reset.fault", 32'(bus1.o_fault), 32'h0);
        chk("reset.busy",  32'(bus1.o_busy),  32'h0);
        chk("reset.rdata", bus2.o_rdata, NOP);
        rst = 1'b0;

        for (int i = 0; i < DEPTH; i++) begin
            step(0, '0, 0, 1, 32'(4 * i),          32'hA000_0000 | 32'(i));
            step(0, '0, 0, 1, 32'h100 + 32'(4 * i), 32'hB000_0000 | 32'(i));
        end

        for (int i = 0; i < 15; i++) begin
            step(vt[i].req, vt[i].raddr, vt[i].flush, vt[i].wen, vt[i].waddr, vt[i].wdata);
            chk($sformatf("vec%0d.valid", i), 32'(bus0.o_valid), 32'(vt[i].e_valid));
            chk($sformatf("vec%0d.fault", i), 32'(bus0.o_fault), 32'(vt[i].e_fault));
            chk($sformatf("vec%0d.busy", i),  32'(bus0.o_busy),  32'h0);
            chk($sformatf("vec%0d.rdata", i), bus0.o_rdata, vt[i].e_rdata);
        end
        idle(6);

        // Three wait states on u1; a request during WAIT must be ignored.
        step(1, 32'h104, 0, 0, '0, '0);
        chk("ws.busy1", 32'(bus1.o_busy), 32'h1);
        step(1, 32'h108, 0, 0, '0, '0);
        chk("ws.busy2", 32'(bus1.o_busy), 32'h1);
        step(0, '0, 0, 0, '0, '0);
        chk("ws.busy3", 32'(bus1.o_busy), 32'h1);
        chk("ws.early", 32'(bus1.o_valid), 32'h0);
        step(0, '0, 0, 0, '0, '0);
        chk("ws.valid", 32'(bus1.o_valid), 32'h1);
        chk("ws.busy4", 32'(bus1.o_busy), 32'h0);
        chk("ws.rdata", bus1.o_rdata, 32'hB000_0001);
        step(0, '0, 0, 0, '0, '0);
        chk("ws.nodup", 32'(bus1.o_valid), 32'h0);
        chk("ws.hold",  bus1.o_rdata, 32'hB000_0001);
        idle(6);

        // Flush during WAIT on u2, then a fresh request answered normally.
        step(1, 32'h4, 0, 0, '0, '0);
        chk("fl.busy", 32'(bus2.o_busy), 32'h1);
        step(0, '0, 1, 0, '0, '0);
        chk("fl.busy0",  32'(bus2.o_busy),  32'h0);
        chk("fl.rdata",  bus2.o_rdata, NOP);
        step(1, 32'h8, 0, 0, '0, '0);
        chk("fl.busy_new", 32'(bus2.o_busy), 32'h1);
        step(0, '0, 0, 0, '0, '0);
        chk("fl.novalid", 32'(bus2.o_valid), 32'h0);
        step(0, '0, 0, 0, '0, '0);
        chk("fl.valid", 32'(bus2.o_valid), 32'h1);
        chk("fl.data",  bus2.o_rdata, 32'hDEAD_BEEF);
        idle(6);

        // Fetch just below a non-zero base.
        step(1, 32'hFC, 0, 0, '0, '0);
        idle(3);
        chk("lo.valid", 32'(bus1.o_valid), 32'h1);
        chk("lo.fault", 32'(bus1.o_fault), 32'h1);
        chk("lo.rdata", bus1.o_rdata, NOP);
        idle(6);

        // Reset abandons an in-flight request.
        step(1, 32'h100, 0, 0, '0, '0);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        chk("rr.busy", 32'(bus1.o_busy), 32'h0);
        chk("rr.rdata", bus1.o_rdata, NOP);
        for (int i = 0; i < 4; i++) begin
            idle(1);
            chk($sformatf("rr.valid%0d", i), 32'(bus1.o_valid), 32'h0);
        end

        for (int i = 0; i < 1500; i++) begin
            logic        r, f, w;
            logic [31:0] ra, wa, wd;
            rst = ($urandom_range(0, 249) == 0);
            r   = ($urandom_range(0, 1) == 1);
            f   = ($urandom_range(0, 9) == 0);
            w   = !rst && ($urandom_range(0, 3) == 0);
            ra  = rnd_addr();
            wa  = rnd_addr();
            wd  = 32'($urandom());
            step(r, ra, f, w, wa, wd);
        end
        rst = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
